// File: rtl/axi4lite_dist_n.sv
`default_nettype none
// ============================================================================
// Module  : axi4lite_dist_n
// Brief   : AXI4-Lite 1:N address-decoded distributor with internal DECERR.
// Revision: 1.0 - initial release
// ============================================================================
module axi4lite_dist_n #(
    parameter int NUM_PORTS = 5,
    parameter int SEL_LSB   = 24,
    parameter int SEL_W     = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STRB_W    = DATA_W / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        inport_awvalid_i,
    output logic                        inport_awready_o,
    input  logic [ADDR_W-1:0]           inport_awaddr_i,
    input  logic                        inport_wvalid_i,
    output logic                        inport_wready_o,
    input  logic [DATA_W-1:0]           inport_wdata_i,
    input  logic [STRB_W-1:0]           inport_wstrb_i,
    output logic                        inport_bvalid_o,
    input  logic                        inport_bready_i,
    output logic [1:0]                  inport_bresp_o,
    input  logic                        inport_arvalid_i,
    output logic                        inport_arready_o,
    input  logic [ADDR_W-1:0]           inport_araddr_i,
    output logic                        inport_rvalid_o,
    input  logic                        inport_rready_i,
    output logic [DATA_W-1:0]           inport_rdata_o,
    output logic [1:0]                  inport_rresp_o,
    output logic [NUM_PORTS-1:0]        outport_awvalid_o,
    input  logic [NUM_PORTS-1:0]        outport_awready_i,
    output logic [ADDR_W-1:0]           outport_awaddr_o,
    output logic [NUM_PORTS-1:0]        outport_wvalid_o,
    input  logic [NUM_PORTS-1:0]        outport_wready_i,
    output logic [DATA_W-1:0]           outport_wdata_o,
    output logic [STRB_W-1:0]           outport_wstrb_o,
    input  logic [NUM_PORTS-1:0]        outport_bvalid_i,
    input  logic [NUM_PORTS*2-1:0]      outport_bresp_i,
    output logic [NUM_PORTS-1:0]        outport_bready_o,
    output logic [NUM_PORTS-1:0]        outport_arvalid_o,
    input  logic [NUM_PORTS-1:0]        outport_arready_i,
    output logic [ADDR_W-1:0]           outport_araddr_o,
    input  logic [NUM_PORTS-1:0]        outport_rvalid_i,
    input  logic [NUM_PORTS*2-1:0]      outport_rresp_i,
    input  logic [NUM_PORTS*DATA_W-1:0] outport_rdata_i,
    output logic [NUM_PORTS-1:0]        outport_rready_o
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_ISSUE = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] W_ERR   = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;
    localparam logic [1:0] R_ERR   = 2'd3;

    localparam logic [1:0] c_DECERR = 2'b11;

    logic [1:0]           r_wstate;
    logic                 r_aw_held;
    logic                 r_w_held;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic [ADDR_W-1:0]    r_awaddr;
    logic [DATA_W-1:0]    r_wdata;
    logic [STRB_W-1:0]    r_wstrb;
    logic [SEL_W-1:0]     r_wsel;

    logic [1:0]           r_rstate;
    logic [ADDR_W-1:0]    r_araddr;
    logic [SEL_W-1:0]     r_rsel;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic [ADDR_W-1:0]    w_awaddr_cur;
    logic [SEL_W-1:0]     w_wsel_new;
    logic                 w_wsel_ok;
    logic [SEL_W-1:0]     w_rsel_new;
    logic                 w_rsel_ok;
    logic [NUM_PORTS-1:0] w_wsel_oh;
    logic [NUM_PORTS-1:0] w_rsel_oh;
    logic                 w_aw_sel_rdy;
    logic                 w_w_sel_rdy;
    logic                 w_ar_sel_rdy;
    logic [1:0]           w_bresp_sel;
    logic [1:0]           w_rresp_sel;
    logic [DATA_W-1:0]    w_rdata_sel;

    assign w_aw_hs      = inport_awvalid_i & inport_awready_o;
    assign w_w_hs       = inport_wvalid_i & inport_wready_o;
    // Select decode uses the live address when AW completes in the same cycle.
    assign w_awaddr_cur = r_aw_held ? r_awaddr : inport_awaddr_i;
    assign w_wsel_new   = w_awaddr_cur[SEL_LSB +: SEL_W];
    assign w_wsel_ok    = int'(w_wsel_new) < NUM_PORTS;
    assign w_rsel_new   = inport_araddr_i[SEL_LSB +: SEL_W];
    assign w_rsel_ok    = int'(w_rsel_new) < NUM_PORTS;

    always_comb begin
        w_wsel_oh   = '0;
        w_rsel_oh   = '0;
        w_bresp_sel = '0;
        w_rresp_sel = '0;
        w_rdata_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_wsel_oh[k] = (int'(r_wsel) == k);
            w_rsel_oh[k] = (int'(r_rsel) == k);
            if (int'(r_wsel) == k) begin
                w_bresp_sel = outport_bresp_i[2*k +: 2];
            end
            if (int'(r_rsel) == k) begin
                w_rresp_sel = outport_rresp_i[2*k +: 2];
                w_rdata_sel = outport_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_aw_sel_rdy = |(outport_awready_i & w_wsel_oh);
    assign w_w_sel_rdy  = |(outport_wready_i & w_wsel_oh);
    assign w_ar_sel_rdy = |(outport_arready_i & w_rsel_oh);

    assign inport_awready_o  = !rst_i && (r_wstate == W_IDLE) && !r_aw_held;
    assign inport_wready_o   = !rst_i && (r_wstate == W_IDLE) && !r_w_held;
    assign outport_awvalid_o = (!rst_i && (r_wstate == W_ISSUE) && !r_aw_done) ? w_wsel_oh : '0;
    assign outport_wvalid_o  = (!rst_i && (r_wstate == W_ISSUE) && !r_w_done) ? w_wsel_oh : '0;
    assign outport_awaddr_o  = r_awaddr;
    assign outport_wdata_o   = r_wdata;
    assign outport_wstrb_o   = r_wstrb;
    assign outport_bready_o  = (!rst_i && (r_wstate == W_RESP) && inport_bready_i) ? w_wsel_oh : '0;
    assign inport_bvalid_o   = !rst_i && (((r_wstate == W_RESP) && |(outport_bvalid_i & w_wsel_oh))
                                          || (r_wstate == W_ERR));
    assign inport_bresp_o    = (r_wstate == W_ERR) ? c_DECERR : w_bresp_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wsel    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= inport_awaddr_i;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= inport_wdata_i;
                        r_wstrb  <= inport_wstrb_i;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                        r_wsel   <= w_wsel_new;
                        r_wstate <= w_wsel_ok ? W_ISSUE : W_ERR;
                    end
                end
                W_ISSUE: begin
                    if (w_aw_sel_rdy) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_sel_rdy) begin
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_sel_rdy) && (r_w_done || w_w_sel_rdy)) begin
                        r_wstate <= W_RESP;
                    end
                end
                default: begin
                    if (inport_bvalid_o && inport_bready_i) begin
                        r_wstate  <= W_IDLE;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign inport_arready_o  = !rst_i && (r_rstate == R_IDLE);
    assign outport_arvalid_o = (!rst_i && (r_rstate == R_ISSUE)) ? w_rsel_oh : '0;
    assign outport_araddr_o  = r_araddr;
    assign outport_rready_o  = (!rst_i && (r_rstate == R_RESP) && inport_rready_i) ? w_rsel_oh : '0;
    assign inport_rvalid_o   = !rst_i && (((r_rstate == R_RESP) && |(outport_rvalid_i & w_rsel_oh))
                                          || (r_rstate == R_ERR));
    assign inport_rresp_o    = (r_rstate == R_ERR) ? c_DECERR : w_rresp_sel;
    assign inport_rdata_o    = (r_rstate == R_ERR) ? '0 : w_rdata_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_rsel   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (inport_arvalid_i) begin
                        r_araddr <= inport_araddr_i;
                        r_rsel   <= w_rsel_new;
                        r_rstate <= w_rsel_ok ? R_ISSUE : R_ERR;
                    end
                end
                R_ISSUE: begin
                    if (w_ar_sel_rdy) begin
                        r_rstate <= R_RESP;
                    end
                end
                default: begin
                    if (inport_rvalid_o && inport_rready_i) begin
                        r_rstate <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_dist_n.sv
`default_nettype none
// Directed testbench for axi4lite_dist_n: 5-port instance plus a 16-port/64-bit instance.
module tb_axi4lite_dist_n;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // 5-port, 32-bit instance
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [4:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [4:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [9:0]  s_bresp, s_rresp;
    logic [159:0] s_rdata;

    axi4lite_dist_n u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport_awvalid_i(m_awvalid), .inport_awready_o(m_awready), .inport_awaddr_i(m_awaddr),
        .inport_wvalid_i(m_wvalid), .inport_wready_o(m_wready), .inport_wdata_i(m_wdata),
        .inport_wstrb_i(m_wstrb), .inport_bvalid_o(m_bvalid), .inport_bready_i(m_bready),
        .inport_bresp_o(m_bresp), .inport_arvalid_i(m_arvalid), .inport_arready_o(m_arready),
        .inport_araddr_i(m_araddr), .inport_rvalid_o(m_rvalid), .inport_rready_i(m_rready),
        .inport_rdata_o(m_rdata), .inport_rresp_o(m_rresp),
        .outport_awvalid_o(s_awvalid), .outport_awready_i(s_awready), .outport_awaddr_o(s_awaddr),
        .outport_wvalid_o(s_wvalid), .outport_wready_i(s_wready), .outport_wdata_o(s_wdata),
        .outport_wstrb_o(s_wstrb), .outport_bvalid_i(s_bvalid), .outport_bresp_i(s_bresp),
        .outport_bready_o(s_bready), .outport_arvalid_o(s_arvalid), .outport_arready_i(s_arready),
        .outport_araddr_o(s_araddr), .outport_rvalid_i(s_rvalid), .outport_rresp_i(s_rresp),
        .outport_rdata_i(s_rdata), .outport_rready_o(s_rready)
    );

    // 16-port, 64-bit instance
    logic         h_awvalid, h_awready, h_wvalid, h_wready, h_bvalid, h_bready;
    logic         h_arvalid, h_arready, h_rvalid, h_rready;
    logic [31:0]  h_awaddr, h_araddr;
    logic [63:0]  h_wdata, h_rdata;
    logic [7:0]   h_wstrb;
    logic [1:0]   h_bresp, h_rresp;
    logic [15:0]  hs_awvalid, hs_awready, hs_wvalid, hs_wready, hs_bvalid, hs_bready;
    logic [15:0]  hs_arvalid, hs_arready, hs_rvalid, hs_rready;
    logic [31:0]  hs_awaddr, hs_araddr;
    logic [63:0]  hs_wdata;
    logic [7:0]   hs_wstrb;
    logic [31:0]  hs_bresp, hs_rresp;
    logic [1023:0] hs_rdata;

    axi4lite_dist_n #(.NUM_PORTS(16), .SEL_LSB(24), .SEL_W(4), .ADDR_W(32), .DATA_W(64)) u_dut16 (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport_awvalid_i(h_awvalid), .inport_awready_o(h_awready), .inport_awaddr_i(h_awaddr),
        .inport_wvalid_i(h_wvalid), .inport_wready_o(h_wready), .inport_wdata_i(h_wdata),
        .inport_wstrb_i(h_wstrb), .inport_bvalid_o(h_bvalid), .inport_bready_i(h_bready),
        .inport_bresp_o(h_bresp), .inport_arvalid_i(h_arvalid), .inport_arready_o(h_arready),
        .inport_araddr_i(h_araddr), .inport_rvalid_o(h_rvalid), .inport_rready_i(h_rready),
        .inport_rdata_o(h_rdata), .inport_rresp_o(h_rresp),
        .outport_awvalid_o(hs_awvalid), .outport_awready_i(hs_awready), .outport_awaddr_o(hs_awaddr),
        .outport_wvalid_o(hs_wvalid), .outport_wready_i(hs_wready), .outport_wdata_o(hs_wdata),
        .outport_wstrb_o(hs_wstrb), .outport_bvalid_i(hs_bvalid), .outport_bresp_i(hs_bresp),
        .outport_bready_o(hs_bready), .outport_arvalid_o(hs_arvalid), .outport_arready_i(hs_arready),
        .outport_araddr_o(hs_araddr), .outport_rvalid_i(hs_rvalid), .outport_rresp_i(hs_rresp),
        .outport_rdata_i(hs_rdata), .outport_rready_o(hs_rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} = '0;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_araddr = '0;
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
        s_bresp = '0; s_rresp = '0; s_rdata = '0;
        {h_awvalid, h_wvalid, h_bready, h_arvalid, h_rready} = '0;
        h_awaddr = '0; h_wdata = '0; h_wstrb = '0; h_araddr = '0;
        {hs_awready, hs_wready, hs_bvalid, hs_arready, hs_rvalid} = '0;
        hs_bresp = '0; hs_rresp = '0; hs_rdata = '0;

        repeat (3) tick();
        chk("rst_awready", m_awready, 0);
        chk("rst_arready", m_arready, 0);
        chk("rst_awvalid", s_awvalid, 0);
        chk("rst_awaddr", s_awaddr, 0);
        rst_i = 1'b0;
        #1;
        chk("rel_awready", m_awready, 1);
        chk("rel_wready", m_wready, 1);
        chk("rel_arready", m_arready, 1);
        chk("rel_bvalid", m_bvalid, 0);

        // T1: AW and W together to slave 2
        m_awaddr = 32'h0200_0010; m_awvalid = 1; m_wdata = 32'h1234_5678; m_wstrb = 4'hF; m_wvalid = 1;
        tick();
        m_awvalid = 0; m_wvalid = 0; #1;
        chk("t1_awvalid", s_awvalid, 5'b00100);
        chk("t1_wvalid", s_wvalid, 5'b00100);
        chk("t1_awaddr", s_awaddr, 32'h0200_0010);
        chk("t1_wdata", s_wdata, 32'h1234_5678);
        chk("t1_awready_busy", m_awready, 0);
        s_awready = 5'b00100; s_wready = 5'b00100;
        tick();
        s_awready = 0; s_wready = 0;
        s_bvalid = 5'b00100; s_bresp = '0; m_bready = 1; #1;
        chk("t1_awvalid_drop", s_awvalid, 0);
        chk("t1_bvalid", m_bvalid, 1);
        chk("t1_bresp", m_bresp, 0);
        chk("t1_bready_route", s_bready, 5'b00100);
        tick();
        s_bvalid = 0; m_bready = 0; #1;
        chk("t1_bvalid_done", m_bvalid, 0);
        chk("t1_awready_back", m_awready, 1);

        // T2: AW at cycle 0, W at cycle 3, slave 1 ready at 5 (AW) and 7 (W)
        m_awaddr = 32'h0100_0004; m_awvalid = 1;
        tick();
        m_awvalid = 0; #1;
        chk("t2_awready_held", m_awready, 0);
        chk("t2_wready_open", m_wready, 1);
        chk("t2_no_issue", s_awvalid, 0);
        tick(); tick();
        m_wdata = 32'hCAFE_F00D; m_wstrb = 4'h3; m_wvalid = 1;
        tick();
        m_wvalid = 0; #1;
        chk("t2_awvalid_c4", s_awvalid, 5'b00010);
        chk("t2_wvalid_c4", s_wvalid, 5'b00010);
        chk("t2_wstrb", s_wstrb, 4'h3);
        tick();
        s_awready = 5'b00010;
        tick();
        s_awready = 0; #1;
        chk("t2_awvalid_c6", s_awvalid, 0);
        chk("t2_wvalid_c6", s_wvalid, 5'b00010);
        chk("t2_wdata_stable", s_wdata, 32'hCAFE_F00D);
        tick();
        s_wready = 5'b00010;
        tick();
        s_wready = 0; #1;
        chk("t2_wvalid_c8", s_wvalid, 0);
        s_bvalid = 5'b00010; s_bresp = 10'b00_00_00_10_00; #1;
        chk("t2_bvalid", m_bvalid, 1);
        chk("t2_bresp", m_bresp, 2'b10);
        chk("t2_bready_low", s_bready, 0);
        m_bready = 1; #1;
        chk("t2_bready_route", s_bready, 5'b00010);
        tick();
        m_bready = 0; #1;
        chk("t2_single_bvalid", m_bvalid, 0);
        s_bvalid = 0;

        // T3: read to unmapped select 7
        m_araddr = 32'h0700_0000; m_arvalid = 1;
        tick();
        m_arvalid = 0; #1;
        chk("t3_no_arvalid", s_arvalid, 0);
        chk("t3_rvalid", m_rvalid, 1);
        chk("t3_rresp", m_rresp, 2'b11);
        chk("t3_rdata", m_rdata, 0);
        chk("t3_arready_busy", m_arready, 0);
        tick();
        chk("t3_rvalid_hold", m_rvalid, 1);
        m_rready = 1;
        tick();
        m_rready = 0; #1;
        chk("t3_rvalid_done", m_rvalid, 0);
        chk("t3_arready_back", m_arready, 1);

        // T4: read slave 4 and write slave 0 in parallel; stray slave-3 bvalid
        for (int k = 0; k < 5; k++) s_rdata[k*32 +: 32] = 32'hA5A5_0000 + k;
        s_rresp = 10'b00_11_11_11_11;
        m_araddr = 32'h0400_0040; m_arvalid = 1;
        m_awaddr = 32'h0000_0008; m_awvalid = 1; m_wdata = 32'h0BAD_BEEF; m_wstrb = 4'hC; m_wvalid = 1;
        tick();
        m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
        s_bvalid = 5'b01000; #1;
        chk("t4_arvalid", s_arvalid, 5'b10000);
        chk("t4_araddr", s_araddr, 32'h0400_0040);
        chk("t4_awvalid", s_awvalid, 5'b00001);
        chk("t4_stray_bvalid_issue", m_bvalid, 0);
        s_arready = 5'b10000; s_awready = 5'b00001; s_wready = 5'b00001;
        tick();
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 5'b10000; #1;
        chk("t4_stray_bvalid_resp", m_bvalid, 0);
        chk("t4_rvalid", m_rvalid, 1);
        chk("t4_rdata", m_rdata, 32'hA5A5_0004);
        chk("t4_rresp", m_rresp, 0);
        s_bvalid = 5'b01001; s_bresp = 10'b00_11_00_00_01; m_bready = 1; m_rready = 1; #1;
        chk("t4_bresp", m_bresp, 2'b01);
        chk("t4_bready_route", s_bready, 5'b00001);
        chk("t4_rready_route", s_rready, 5'b10000);
        tick();
        m_bready = 0; m_rready = 0; s_bvalid = 0; s_rvalid = 0; #1;
        chk("t4_bvalid_done", m_bvalid, 0);
        chk("t4_rvalid_done", m_rvalid, 0);

        // T5: master stalls rready for 10 cycles on slave 2 read
        m_araddr = 32'h0200_0100; m_arvalid = 1;
        tick();
        m_arvalid = 0; s_arready = 5'b00100;
        tick();
        s_arready = 0; s_rvalid = 5'b00100;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_rdata_stable", m_rdata, 32'hA5A5_0002);
            chk("t5_rready_low", s_rready, 0);
            tick();
        end
        chk("t5_rresp", m_rresp, 2'b11);
        m_rready = 1; #1;
        chk("t5_rready_route", s_rready, 5'b00100);
        tick();
        m_rready = 0; s_rvalid = 0; #1;
        chk("t5_arready_next", m_arready, 1);
        chk("t5_rvalid_done", m_rvalid, 0);

        // T6: reset while both instances are in W_ISSUE
        m_awaddr = 32'h0300_0000; m_awvalid = 1; m_wdata = 32'h1111_2222; m_wstrb = 4'hF; m_wvalid = 1;
        h_awaddr = 32'h0C00_0020; h_awvalid = 1; h_wdata = 64'h0123_4567_89AB_CDEF; h_wstrb = 8'hFF; h_wvalid = 1;
        tick();
        m_awvalid = 0; m_wvalid = 0; h_awvalid = 0; h_wvalid = 0; #1;
        chk("t6_awvalid", s_awvalid, 5'b01000);
        chk("t6h_awvalid", hs_awvalid, 16'h1000);
        chk("t6h_wdata", hs_wdata, 64'h0123_4567_89AB_CDEF);
        chk("t6h_wstrb", hs_wstrb, 8'hFF);
        rst_i = 1'b1;
        tick();
        chk("t6_awvalid_rst", s_awvalid, 0);
        chk("t6_wvalid_rst", s_wvalid, 0);
        chk("t6h_awvalid_rst", hs_awvalid, 0);
        chk("t6h_wvalid_rst", hs_wvalid, 0);
        rst_i = 1'b0; #1;
        chk("t6_awready", m_awready, 1);
        chk("t6_wready", m_wready, 1);
        chk("t6_bvalid", m_bvalid, 0);
        chk("t6h_awready", h_awready, 1);
        chk("t6h_wready", h_wready, 1);
        chk("t6h_bvalid", h_bvalid, 0);

        // 16-port read to top select 15
        h_araddr = 32'h0F00_0000; h_arvalid = 1;
        tick();
        h_arvalid = 0; #1;
        chk("t6h_arvalid", hs_arvalid, 16'h8000);
        hs_arready = 16'h8000;
        tick();
        hs_arready = 0; hs_rvalid = 16'h8000;
        hs_rdata[15*64 +: 64] = 64'hFEED_FACE_DEAD_0F0F; h_rready = 1; #1;
        chk("t6h_rdata", h_rdata, 64'hFEED_FACE_DEAD_0F0F);
        chk("t6h_rready_route", hs_rready, 16'h8000);
        tick();
        h_rready = 0; hs_rvalid = 0; #1;
        chk("t6h_rvalid_done", h_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
